// File: rtl/round_banner_ctrl.sv
// round_banner_ctrl: sequences the "Round N" banner overlay.
// It latches the round number, selects that round's sprite ROM and palette,
// and maps DrawX/DrawY to sprite addresses. The ROM index is pipelined through
// the shared palette to a registered RGB pixel with a valid flag. The banner
// is held steady for SHOW_FRAMES, blinks for BLINK_FRAMES, then hides.
module round_banner_ctrl #(
    parameter int unsigned SPR_W        = 64,
    parameter int unsigned SPR_H        = 32,
    parameter int unsigned X0           = 288,
    parameter int unsigned Y0           = 224,
    parameter int unsigned MAX_ROUND    = 6,
    parameter int unsigned SHOW_FRAMES  = 120,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned BLINK_PERIOD = 16,
    parameter int unsigned TRANSP_IDX   = 0,
    parameter int unsigned ADDR_W       = $clog2(SPR_W * SPR_H)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              round_start,
    input  logic [2:0]        round_num,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [2:0]        rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_index,
    output logic [3:0]        pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              pix_valid,
    output logic              banner_active
);

    localparam int unsigned CNT_MAX = (SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    // Box edges as 10-bit constants so the compares stay in the coordinate width.
    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + SPR_W);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + SPR_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHOW  = 2'd2,
        BLINK = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               r_visible;
    logic               w_vis_nx;
    logic [2:0]         r_rom_sel;
    logic [2:0]         w_sel_nx;
    logic               r_banner_active;

    logic               w_start_ok;
    logic               w_in_box;
    logic [9:0]         w_dx;
    logic [9:0]         w_dy;
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_in_box1;
    logic               r_in_box2;
    logic               w_pix_opaque;
    logic [11:0]        r_rgb;
    logic               r_pix_valid;

    // Only rounds 1..MAX_ROUND start a banner; anything else is ignored.
    assign w_start_ok = round_start && (round_num != 3'd0) && (round_num <= 3'(MAX_ROUND));

    // Next-state, frame counter, visibility and ROM select.
    // A legal round_start beats a coincident frame_start and restarts from ARM.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_nx = r_state;
        w_cnt_nx   = r_frame_cnt;
        w_vis_nx   = r_visible;
        w_sel_nx   = r_rom_sel;
        if (w_start_ok) begin
            w_state_nx = ARM;
            w_cnt_nx   = '0;
            w_vis_nx   = 1'b0;
            w_sel_nx   = round_num;
        end else if (frame_start) begin
            case (r_state)
                ARM: begin
                    w_state_nx = SHOW;
                    w_cnt_nx   = '0;
                    w_vis_nx   = 1'b1;
                end
                SHOW: begin
                    if (r_frame_cnt == CNT_W'(SHOW_FRAMES - 1)) begin
                        w_state_nx = BLINK;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_frame_cnt + CNT_W'(1);
                    end
                end
                BLINK: begin
                    if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                        w_vis_nx   = 1'b0;
                        w_sel_nx   = 3'd0;
                    end else begin
                        w_cnt_nx = r_frame_cnt + CNT_W'(1);
                        if ((r_frame_cnt % CNT_W'(BLINK_PERIOD)) == CNT_W'(BLINK_PERIOD - 1))
                            w_vis_nx = ~r_visible;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state register; banner_active lags the state by one cycle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_frame_cnt     <= '0;
            r_visible       <= 1'b0;
            r_rom_sel       <= 3'd0;
            r_banner_active <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state         <= w_state_nx;
            r_frame_cnt     <= w_cnt_nx;
            r_visible       <= w_vis_nx;
            r_rom_sel       <= w_sel_nx;
            r_banner_active <= (r_state == SHOW) || (r_state == BLINK);
        end
    end

    // Geometric box test first; the subtractions are only used inside it,
    // so an unsigned wrap never reaches rom_addr.
    assign w_in_box = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
    assign w_dx     = DrawX - X_LO;
    assign w_dy     = DrawY - Y_LO;
    assign w_addr   = ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_dx);

    // Stage 1: sprite address (held outside the box) and the first in-box flag.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_in_box1  <= 1'b0;
        end else begin
            if (w_in_box)
                r_rom_addr <= w_addr;
            r_in_box1 <= blank && r_visible && w_in_box;
        end
    end

    // Stage 2: ROM data arrives; carry the in-box flag alongside it.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_box2 <= 1'b0;
        end else begin
            r_in_box2 <= r_in_box1;
        end
    end

    assign w_pix_opaque = r_in_box2 && (rom_index != 4'(TRANSP_IDX));

    // Stage 3: register palette colour, forced to black when not opaque.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb       <= 12'h000;
            r_pix_valid <= 1'b0;
        end else begin
            r_rgb       <= w_pix_opaque ? pal_rgb : 12'h000;
            r_pix_valid <= w_pix_opaque;
        end
    end

    assign rom_sel            = r_rom_sel;
    assign rom_addr           = r_rom_addr;
    assign pal_index          = rom_index;
    assign {red, green, blue} = r_rgb;
    assign pix_valid          = r_pix_valid;
    assign banner_active      = r_banner_active;

endmodule

// File: tb/tb_round_banner_ctrl.sv
// Self-checking bench for round_banner_ctrl with shortened frame timing.
// Pixel expectations go into scoreboard queues when DrawX/DrawY are driven
// and are compared when the pipeline delivers them.
module tb_round_banner_ctrl;

    localparam int X0 = 288;
    localparam int Y0 = 224;
    localparam int SW = 64;
    localparam int SH = 32;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        round_start = 1'b0;
    logic [2:0]  round_num = 3'd0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        blank = 1'b0;
    logic [2:0]  rom_sel;
    logic [10:0] rom_addr;
    logic [3:0]  rom_index = 4'd0;
    logic [3:0]  pal_index;
    logic [11:0] pal_rgb;
    logic [3:0]  red, green, blue;
    logic        pix_valid;
    logic        banner_active;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [10:0] last_addr = 11'd0;

    typedef struct { int due; logic [10:0] addr; } addr_t;
    typedef struct { int due; logic pv; logic [11:0] rgb; } pix_t;
    addr_t addr_q[$];
    pix_t  pix_q[$];

    round_banner_ctrl #(
        .SHOW_FRAMES (4),
        .BLINK_FRAMES(4),
        .BLINK_PERIOD(2)
    ) dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .round_start  (round_start),
        .round_num    (round_num),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .rom_sel      (rom_sel),
        .rom_addr     (rom_addr),
        .rom_index    (rom_index),
        .pal_index    (pal_index),
        .pal_rgb      (pal_rgb),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .pix_valid    (pix_valid),
        .banner_active(banner_active)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    // ROM contents: low nibble of the address with bit 1 flipped (addr 67 -> 1, addr 2 -> 0).
    function automatic logic [3:0] rom_data(input logic [10:0] a);
        return a[3:0] ^ 4'h2;
    endfunction

    // Palette: index 1 is black, others a recognisable pattern.
    function automatic logic [11:0] pal(input logic [3:0] i);
        return (i == 4'd1) ? 12'h000 : {i, ~i, i ^ 4'h3};
    endfunction

    always @(posedge vga_clk) rom_index <= rom_data(rom_addr);
    assign pal_rgb = pal(pal_index);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard drain: compare entries whose cycle has come.
    always @(negedge vga_clk) begin
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            check("rom_addr", {21'd0, rom_addr}, {21'd0, addr_q[0].addr});
            void'(addr_q.pop_front());
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            check("pix_valid", {31'd0, pix_valid}, {31'd0, pix_q[0].pv});
            check("rgb", {20'd0, red, green, blue}, {20'd0, pix_q[0].rgb});
            void'(pix_q.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    // Drive one pixel and queue its expected address (t+1) and colour (t+3).
    task automatic pix(input int x, input int y, input bit b, input bit vis);
        bit in_box;
        logic [10:0] a;
        logic [3:0]  idx;
        bit pv;
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        in_box = (x >= X0) && (x < X0 + SW) && (y >= Y0) && (y < Y0 + SH);
        a = 11'((y - Y0) * SW + (x - X0));
        if (in_box) last_addr = a;
        addr_q.push_back('{cyc + 1, last_addr});
        idx = rom_data(last_addr);
        pv  = in_box && b && vis && (idx != 4'd0);
        pix_q.push_back('{cyc + 3, pv, pv ? pal(idx) : 12'h000});
    endtask

    // Move the beam outside the box and let the pipeline empty.
    task automatic park();
        @(negedge vga_clk);
        DrawX = 10'd0;
        DrawY = 10'd0;
        blank = 1'b0;
        wait_cyc(4);
    endtask

    task automatic probe(input bit vis);
        pix(X0 + 3, Y0 + 1, 1'b1, vis);
        park();
    endtask

    task automatic frame();
        @(negedge vga_clk);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
    endtask

    task automatic start_round(input logic [2:0] n, input bit with_frame);
        @(negedge vga_clk);
        round_start = 1'b1;
        round_num   = n;
        frame_start = with_frame;
        @(negedge vga_clk);
        round_start = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rom_sel"}, {29'd0, rom_sel}, 32'd0);
        check({tag, "_rom_addr"}, {21'd0, rom_addr}, 32'd0);
        check({tag, "_rgb"}, {20'd0, red, green, blue}, 32'd0);
        check({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        check({tag, "_banner_active"}, {31'd0, banner_active}, 32'd0);
    endtask

    initial begin
        // Power-on reset
        #1;
        check_idle_outputs("por");
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(2);

        // T3: illegal round numbers are ignored
        start_round(3'd0, 1'b0);
        check("t3_rom_sel_0", {29'd0, rom_sel}, 32'd0);
        start_round(3'd7, 1'b0);
        check("t3_rom_sel_7", {29'd0, rom_sel}, 32'd0);
        frame();
        wait_cyc(1);
        check("t3_banner_active", {31'd0, banner_active}, 32'd0);
        probe(1'b0);

        // T2: full SHOW -> BLINK -> IDLE sequence for round 6
        start_round(3'd6, 1'b0);
        check("t2_rom_sel", {29'd0, rom_sel}, 32'd6);
        wait_cyc(1);
        check("t2_arm_inactive", {31'd0, banner_active}, 32'd0);
        probe(1'b0);
        frame();
        wait_cyc(1);
        check("t2_banner_active", {31'd0, banner_active}, 32'd1);

        // T4: address mapping, opaque pixel, transparent pixel
        pix(X0 + 3, Y0 + 1, 1'b1, 1'b1);
        pix(X0 + 2, Y0, 1'b1, 1'b1);
        // T5: edges of the box and blanking
        pix(X0 - 1, Y0 + 1, 1'b1, 1'b1);
        pix(X0 + SW, Y0 + 1, 1'b1, 1'b1);
        pix(X0 + 3, Y0 + 1, 1'b0, 1'b1);
        pix(X0 + SW - 1, Y0 + SH - 1, 1'b1, 1'b1);
        pix(X0 + 5, Y0 + SH, 1'b1, 1'b1);
        pix(X0, Y0 - 1, 1'b1, 1'b1);
        pix(X0 + 17, Y0 + 9, 1'b1, 1'b1);
        park();

        // Remaining SHOW frames: banner stays visible
        for (int i = 0; i < 3; i++) begin
            frame();
            probe(1'b1);
        end
        frame();  // enters BLINK
        check("t2_blink_active", {31'd0, banner_active}, 32'd1);
        probe(1'b1);
        frame();
        probe(1'b1);
        frame();
        probe(1'b0);
        frame();
        probe(1'b0);
        frame();  // back to IDLE
        check("t2_end_rom_sel", {29'd0, rom_sel}, 32'd0);
        wait_cyc(1);
        check("t2_end_inactive", {31'd0, banner_active}, 32'd0);
        probe(1'b0);

        // T6: restart during BLINK with coincident frame_start
        start_round(3'd2, 1'b0);
        check("t6_rom_sel_2", {29'd0, rom_sel}, 32'd2);
        for (int i = 0; i < 5; i++) frame();
        frame();  // BLINK, count 1
        wait_cyc(1);
        check("t6_in_blink", {31'd0, banner_active}, 32'd1);
        start_round(3'd3, 1'b1);
        check("t6_rom_sel_3", {29'd0, rom_sel}, 32'd3);
        wait_cyc(1);
        check("t6_arm_inactive", {31'd0, banner_active}, 32'd0);
        probe(1'b0);
        frame();
        wait_cyc(1);
        check("t6_reshow", {31'd0, banner_active}, 32'd1);
        probe(1'b1);

        // T1: asynchronous reset in the middle of SHOW
        pix(X0 + 17, Y0 + 9, 1'b1, 1'b1);
        park();
        @(negedge vga_clk);
        reset_n = 1'b0;
        last_addr = 11'd0;
        #1;
        check_idle_outputs("t1");
        wait_cyc(2);
        reset_n = 1'b1;
        probe(1'b0);
        frame();
        wait_cyc(1);
        check("t1_stays_idle", {31'd0, banner_active}, 32'd0);
        check("t1_rom_sel", {29'd0, rom_sel}, 32'd0);

        wait_cyc(5);
        check("addr_q_drained", addr_q.size(), 32'd0);
        check("pix_q_drained", pix_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
